// File: rtl/fft_iter_ctrl.sv
// fft_iter_ctrl: sequencing controller for an in-place radix-2 DIT iterative FFT.
// Walks log2(N) stages of N/2 butterflies each, issues read address pairs,
// replays them as write-back pairs PIPE_LAT cycles later, and drives the
// twiddle generator's clear/enable/layer-advance inputs.
module fft_iter_ctrl #(
  parameter int AWL      = 5,  // log2(N), data address width
  parameter int PIPE_LAT = 2   // read-issue to write-back latency, >= 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  output logic           BUSY,
  output logic           DONE,
  output logic           RD_EN,
  output logic [AWL-1:0] RD_ADDR_A,
  output logic [AWL-1:0] RD_ADDR_B,
  output logic           WR_EN,
  output logic [AWL-1:0] WR_ADDR_A,
  output logic [AWL-1:0] WR_ADDR_B,
  output logic           TW_CLR,
  output logic           TW_EN,
  output logic           TW_LAY_EN
);

  localparam int SW = (AWL > 1) ? $clog2(AWL) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [AWL-2:0] J_LAST = '1;                  // N/2-1
  localparam logic [AWL-2:0] J_ONE  = (AWL-1)'(1);
  localparam logic [SW-1:0]  S_LAST = SW'(AWL - 1);
  localparam logic [SW-1:0]  S_ONE  = SW'(1);
  localparam logic [DW-1:0]  D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [DW-1:0]  D_ONE  = DW'(1);

  logic [2:0]     state_q, state_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [AWL-2:0] j_q, j_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;

  logic           busy_q, busy_d, done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic [AWL-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic           tw_clr_q, tw_clr_d, tw_en_q, tw_en_d, tw_lay_q, tw_lay_d;

  logic [PIPE_LAT-1:0]          wp_en_q, wp_en_d;
  logic [PIPE_LAT-1:0][AWL-1:0] wp_a_q, wp_a_d, wp_b_q, wp_b_d;

  // Insert a zero bit at position s of butterfly index j.
  function automatic logic [AWL-1:0] ins_zero(input logic [AWL-2:0] j, input logic [SW-1:0] s);
    logic [AWL-1:0] jx, mask;
    jx   = {1'b0, j};
    mask = (AWL'(1) << s) - AWL'(1);
    return ((jx & ~mask) << 1) | (jx & mask);
  endfunction

  // Next-state and counter update for the stage/butterfly/drain sequencing.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_INIT;
      S_INIT: begin
        stage_d = '0;
        j_d     = '0;
        dcnt_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (j_q == J_LAST) begin
          j_d     = '0;
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + J_ONE;
        end
      end
      S_DRAIN: begin
        // Hold off the next stage's reads until the last write-back has landed.
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = S_FIN;
          end else begin
            stage_d = stage_q + S_ONE;
            state_d = S_RUN;
          end
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rd_en_d  = (state_d == S_RUN);
    tw_en_d  = rd_en_d;
    tw_lay_d = rd_en_d && (j_d == J_LAST);
    tw_clr_d = (state_d == S_INIT);
    busy_d   = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_FIN);
    rd_a_d   = '0;
    rd_b_d   = '0;
    if (rd_en_d) begin
      rd_a_d = ins_zero(j_d, stage_d);
      rd_b_d = rd_a_d | (AWL'(1) << stage_d);
    end
  end

  // Write-back delay line: the issued read pair replayed PIPE_LAT cycles later.
  always_comb begin
    wp_en_d    = wp_en_q;
    wp_a_d     = wp_a_q;
    wp_b_d     = wp_b_q;
    wp_en_d[0] = rd_en_q;
    wp_a_d[0]  = rd_a_q;
    wp_b_d[0]  = rd_b_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wp_en_d[i] = wp_en_q[i-1];
      wp_a_d[i]  = wp_a_q[i-1];
      wp_b_d[i]  = wp_b_q[i-1];
    end
  end

  // State, counters, outputs and delay line; reset also drops pending write-backs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      j_q      <= '0;
      dcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      tw_clr_q <= 1'b0;
      tw_en_q  <= 1'b0;
      tw_lay_q <= 1'b0;
      wp_en_q  <= '0;
      wp_a_q   <= '0;
      wp_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      j_q      <= j_d;
      dcnt_q   <= dcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      tw_clr_q <= tw_clr_d;
      tw_en_q  <= tw_en_d;
      tw_lay_q <= tw_lay_d;
      wp_en_q  <= wp_en_d;
      wp_a_q   <= wp_a_d;
      wp_b_q   <= wp_b_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RD_EN     = rd_en_q;
  assign RD_ADDR_A = rd_a_q;
  assign RD_ADDR_B = rd_b_q;
  assign WR_EN     = wp_en_q[PIPE_LAT-1];
  assign WR_ADDR_A = wp_a_q[PIPE_LAT-1];
  assign WR_ADDR_B = wp_b_q[PIPE_LAT-1];
  assign TW_CLR    = tw_clr_q;
  assign TW_EN     = tw_en_q;
  assign TW_LAY_EN = tw_lay_q;

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Scoreboard bench for fft_iter_ctrl: a small (AWL=3, PIPE_LAT=2) instance with
// per-cycle event checking plus a twiddle generator model, and a large
// (AWL=5, PIPE_LAT=4) instance for a latency/coverage sweep.
module tb_fft_iter_ctrl;
  localparam int AWL = 3, PL = 2, N = 8, H = 4;
  localparam int LEN = 1 + AWL*(H+PL) + 1;   // START-to-DONE distance
  localparam int AWL2 = 5, PL2 = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic busy, done, rd_en, wr_en, tw_clr, tw_en, tw_lay;
  logic [AWL-1:0] rd_a, rd_b, wr_a, wr_b;
  logic b_busy, b_done, b_rd_en, b_wr_en, b_tw_clr, b_tw_en, b_tw_lay;
  logic [AWL2-1:0] b_rd_a, b_rd_b, b_wr_a, b_wr_b;

  fft_iter_ctrl #(.AWL(AWL), .PIPE_LAT(PL)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done),
    .RD_EN(rd_en), .RD_ADDR_A(rd_a), .RD_ADDR_B(rd_b),
    .WR_EN(wr_en), .WR_ADDR_A(wr_a), .WR_ADDR_B(wr_b),
    .TW_CLR(tw_clr), .TW_EN(tw_en), .TW_LAY_EN(tw_lay));

  fft_iter_ctrl #(.AWL(AWL2), .PIPE_LAT(PL2)) dut_b (
    .CLK(clk), .RST(rst), .START(start2), .BUSY(b_busy), .DONE(b_done),
    .RD_EN(b_rd_en), .RD_ADDR_A(b_rd_a), .RD_ADDR_B(b_rd_b),
    .WR_EN(b_wr_en), .WR_ADDR_A(b_wr_a), .WR_ADDR_B(b_wr_b),
    .TW_CLR(b_tw_clr), .TW_EN(b_tw_en), .TW_LAY_EN(b_tw_lay));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int b; int lay; int w; } ev_t;
  ev_t exp_rd[$], exp_wr[$];
  int  exp_done[$], exp_clr[$];
  int  busy_lo = -1, busy_hi = -2;
  int  n_chk = 0, n_fail = 0;
  bit  mon_en = 1'b0;
  ev_t me;

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every butterfly of every stage, in issue order.
  task automatic push_run(int t0);
    ev_t e;
    int k;
    exp_clr.push_back(t0 + 1);
    busy_lo = t0 + 1;
    busy_hi = t0 + LEN - 1;
    for (int s = 0; s < AWL; s++) begin
      k = 0;
      for (int a = 0; a < N; a++) begin
        if (((a >> s) & 1) == 0) begin
          e.cyc = t0 + 2 + s*(H+PL) + k;
          e.a   = a;
          e.b   = a + (1 << s);
          e.lay = (k == H-1) ? 1 : 0;
          e.w   = (a % (1 << s)) * (H >> s);
          exp_rd.push_back(e);
          e.cyc = e.cyc + PL;
          exp_wr.push_back(e);
          k++;
        end
      end
    end
    exp_done.push_back(t0 + LEN);
  endtask

  task automatic flush();
    exp_rd.delete(); exp_wr.delete(); exp_done.delete(); exp_clr.delete();
    busy_lo = -1; busy_hi = -2;
  endtask

  task automatic chk_zero(string name);
    chk(name, int'({busy, done, rd_en, wr_en, tw_clr, tw_en, tw_lay}) + int'(rd_a) + int'(rd_b)
              + int'(wr_a) + int'(wr_b), 0);
  endtask

  // Twiddle generator model driven by the controller outputs.
  int tw_addr = 0, tw_step = H;
  always @(posedge clk) begin
    if (tw_clr) begin
      tw_addr <= 0; tw_step <= H;
    end else if (tw_lay) begin
      tw_addr <= 0; tw_step <= tw_step / 2;
    end else if (tw_en) begin
      tw_addr <= (tw_addr + tw_step) % H;
    end
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin chk("rd_missed", cyc, exp_rd[0].cyc); void'(exp_rd.pop_front()); end
      while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin chk("wr_missed", cyc, exp_wr[0].cyc); void'(exp_wr.pop_front()); end
      while (exp_done.size() > 0 && exp_done[0] < cyc) begin chk("done_missed", cyc, exp_done[0]); void'(exp_done.pop_front()); end
      while (exp_clr.size() > 0 && exp_clr[0] < cyc) begin chk("clr_missed", cyc, exp_clr[0]); void'(exp_clr.pop_front()); end
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          me = exp_rd.pop_front();
          chk("rd_cycle", cyc, me.cyc);
          chk("rd_addr_a", int'(rd_a), me.a);
          chk("rd_addr_b", int'(rd_b), me.b);
          chk("tw_en", int'(tw_en), 1);
          chk("tw_lay_en", int'(tw_lay), me.lay);
          chk("w_addr", tw_addr, me.w);
        end
      end else if (tw_en || tw_lay) chk("tw_without_rd", 1, 0);
      if (wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          me = exp_wr.pop_front();
          chk("wr_cycle", cyc, me.cyc);
          chk("wr_addr_a", int'(wr_a), me.a);
          chk("wr_addr_b", int'(wr_b), me.b);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
      if (tw_clr) begin
        if (exp_clr.size() == 0) chk("clr_unexpected", 1, 0);
        else chk("clr_cycle", cyc, exp_clr.pop_front());
      end
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  // Sweep instance tallies.
  int b_seen[AWL2][1<<AWL2];
  int b_rdcnt = 0, b_wrcnt = 0, b_bad = 0, b_done_cyc = -1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (b_rd_en) begin
        if (b_rdcnt / 16 < AWL2) begin
          b_seen[b_rdcnt/16][b_rd_a]++;
          b_seen[b_rdcnt/16][b_rd_b]++;
          if (((int'(b_rd_a) >> (b_rdcnt/16)) & 1) != 0 || int'(b_rd_b) != int'(b_rd_a) + (1 << (b_rdcnt/16)))
            b_bad++;
        end else b_bad++;
        b_rdcnt++;
      end
      if (b_wr_en) b_wrcnt++;
      if (b_done && b_done_cyc < 0) b_done_cyc = cyc;
    end
  end

  // One START-driven run; abort>0 asserts RST in that cycle after START.
  task automatic run(int abort);
    int t0;
    repeat ($urandom_range(0, 3)) step();
    start = 1'b1;
    t0 = cyc;
    push_run(t0);
    for (int c = 1; c <= LEN; c++) begin
      step();
      if (abort != 0 && c == abort) begin
        rst = 1'b1; start = 1'b0;
        step();
        flush();
        rst = 1'b0;
        @(negedge clk);
        chk_zero("zero_after_abort");
        return;
      end
      start = ($urandom_range(0, 2) == 0) || (c == LEN);  // ignored outside IDLE
    end
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; start2 = 1'b1;
    step(); mon_en = 1'b1; step();
    @(negedge clk);
    chk_zero("reset_outputs");
    chk("reset_outputs_b", int'({b_busy, b_done, b_rd_en, b_wr_en, b_tw_clr, b_tw_en, b_tw_lay}), 0);
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    for (int r = 0; r < 6; r++)
      run(r == 2 ? 9 : (r == 4 ? int'($urandom_range(2, LEN-2)) : 0));
    repeat (4) step();
    chk("leftover_events", exp_rd.size() + exp_wr.size() + exp_done.size() + exp_clr.size(), 0);

    begin : sweep
      int bt0, ok;
      start2 = 1'b1;
      bt0 = cyc;
      step();
      start2 = 1'b0;
      for (int i = 0; i < 300 && b_done_cyc < 0; i++) step();
      chk("sweep_done_latency", b_done_cyc - bt0, 102);
      repeat (4) step();
      chk("sweep_rd_count", b_rdcnt, AWL2*16);
      chk("sweep_wr_count", b_wrcnt, AWL2*16);
      chk("sweep_pair_shape", b_bad, 0);
      for (int s = 0; s < AWL2; s++) begin
        ok = 0;
        for (int a = 0; a < 32; a++) ok += (b_seen[s][a] == 1) ? 1 : 0;
        chk("sweep_stage_cover", ok, 32);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
